// File: rtl/md_pkg.sv
// Shared MD-unit definitions: operation encodings, controller states, default timings.
// Imported by the MDU datapath and by the decode logic that drives md_op.
package md_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;
   localparam logic [2:0] MD_RSVD  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } md_state_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned divider: truncating quotient, remainder follows dividend sign.
// Zero-latency; flags divide-by-zero and resolves MIN/-1 to quotient MIN, remainder 0.
module md_div_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             signed_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             zero_o
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic             a_neg, b_neg, ovf;
   logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag;

   always_comb begin
      zero_o = (b_i == '0);
      a_neg  = signed_i & a_i[WIDTH-1];
      b_neg  = signed_i & b_i[WIDTH-1];
      a_mag  = a_neg ? (~a_i + 1'b1) : a_i;
      b_mag  = b_neg ? (~b_i + 1'b1) : b_i;
      // Keep the operator away from a zero divisor; the result is discarded anyway.
      b_safe = zero_o ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      ovf    = signed_i & (a_i == MIN_VAL) & (b_i == '1);
      if (zero_o) begin
         quo_o = '0;
         rem_o = '0;
      end else if (ovf) begin
         quo_o = MIN_VAL;
         rem_o = '0;
      end else begin
         quo_o = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
         rem_o = a_neg ? (~r_mag + 1'b1) : r_mag;
      end
   end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO: result computed at start, committed after N busy cycles.
// Starts while busy are ignored; stall_req freezes F/D while a D-stage MD user would race the unit.
module e_mdu
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             md_start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             d_md_use,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             stall_req
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, ph_q, ph_d, pl_q, pl_d;

   logic             is_mul, is_div;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH-1:0] div_quo, div_rem;
   logic             div_zero;

   assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
   assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);

   // Operands widened to 2*WIDTH so a single unsigned multiply yields the signed product too.
   always_comb begin
      if (md_op == MD_MULT) begin
         mul_a = {{WIDTH{src_a[WIDTH-1]}}, src_a};
         mul_b = {{WIDTH{src_b[WIDTH-1]}}, src_b};
      end else begin
         mul_a = {{WIDTH{1'b0}}, src_a};
         mul_b = {{WIDTH{1'b0}}, src_b};
      end
   end
   assign prod = mul_a * mul_b;

   md_div_core #(.WIDTH(WIDTH)) u_div (
      .a_i      (src_a),
      .b_i      (src_b),
      .signed_i (md_op == MD_DIV),
      .quo_o    (div_quo),
      .rem_o    (div_rem),
      .zero_o   (div_zero)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      ph_d    = ph_q;
      pl_d    = pl_q;
      case (state_q)
         IDLE: begin
            if (md_start) begin
               if (is_mul) begin
                  ph_d    = prod[2*WIDTH-1:WIDTH];
                  pl_d    = prod[WIDTH-1:0];
                  cnt_d   = CW'(MULT_CYCLES);
                  state_d = MUL;
               end else if (is_div) begin
                  // Divide by zero re-commits the current HI/LO, leaving them unchanged.
                  ph_d    = div_zero ? hi_q : div_rem;
                  pl_d    = div_zero ? lo_q : div_quo;
                  cnt_d   = CW'(DIV_CYCLES);
                  state_d = DIV;
               end else if (md_op == MD_MTHI) begin
                  hi_d = src_a;
               end else if (md_op == MD_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         MUL, DIV: begin
            if (cnt_q == CW'(1)) begin
               hi_d    = ph_q;
               lo_d    = pl_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ph_q    <= '0;
         pl_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign stall_req = d_md_use & (busy | (md_start & (is_mul | is_div)));

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: driver pushes expected HI/LO and busy length per accepted op,
// monitor pops on each commit (busy falling) or mthi/mtlo write.
module tb_e_mdu;
   import md_pkg::*;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         md_start = 1'b0;
   logic [2:0]   md_op = MD_NONE;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         d_md_use = 1'b0;
   logic         busy, stall_req;
   logic [W-1:0] hi, lo;

   e_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .md_start  (md_start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .d_md_use  (d_md_use),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           blen;
      bit           is_mt;
   } exp_t;

   exp_t         exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural reference: plain 64-bit arithmetic, returns {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, b,
                                         input logic [W-1:0] h, l);
      longint          sa, sb, p, q, r;
      longint unsigned pu;
      logic [W-1:0]    nh, nl;
      nh = h;
      nl = l;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT:  begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
         MD_MULTU: begin pu = {32'b0, a} * {32'b0, b}; nh = pu[63:32]; nl = pu[31:0]; end
         MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
         MD_DIVU:  if (b != 0) begin nl = a / b; nh = a % b; end
         MD_MTHI:  nh = a;
         MD_MTLO:  nl = a;
         default:  ;
      endcase
      return {nh, nl};
   endfunction

   function automatic logic [W-1:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         4:       return -W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pops one scoreboard entry per observable HI/LO update.
   logic prev_busy = 1'b0;
   int   run = 0;
   logic mt_acc = 1'b0;

   always @(posedge clk)
      mt_acc <= reset_n && md_start && !busy && (md_op == MD_MTHI || md_op == MD_MTLO);

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset_n) begin
         prev_busy = 1'b0;
         run = 0;
      end else begin
         if (mt_acc) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL mt_event: DUT wrote HI/LO with no expected entry queued");
            end else begin
               e = exp_q.pop_front();
               chk("mt_kind", 64'(e.is_mt), 1);
               chk("mt_hi", hi, e.hi);
               chk("mt_lo", lo, e.lo);
               chk("mt_busy", busy, 0);
            end
         end
         if (busy) run++;
         else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL commit_event: busy fell with no expected entry queued");
            end else begin
               e = exp_q.pop_front();
               chk("md_kind", 64'(e.is_mt), 0);
               chk("commit_hi", hi, e.hi);
               chk("commit_lo", lo, e.lo);
               chk("busy_len", 64'(run), 64'(e.blen));
            end
            run = 0;
         end
         prev_busy = busy;
      end
   end

   // Driver: one op per call; for mult/div it covers the whole busy window.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b,
                        input bit directed, input logic [W-1:0] eh, el, input bit stall_t);
      bit           muldiv, mt;
      int           n;
      exp_t         e;
      logic [63:0]  r;
      muldiv = (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
      mt     = (op == MD_MTHI || op == MD_MTLO);
      n      = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
      r = model(op, a, b, m_hi, m_lo);
      if (directed) r = {eh, el};
      m_hi = r[63:32];
      m_lo = r[31:0];
      if (muldiv || mt) begin
         e.hi = m_hi; e.lo = m_lo; e.blen = muldiv ? n : 0; e.is_mt = mt;
         exp_q.push_back(e);
      end
      md_start = 1'b1; md_op = op; src_a = a; src_b = b;
      d_md_use = stall_t ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_start", stall_req, 64'(d_md_use & muldiv));
      @(posedge clk); #1;
      md_start = 1'b0; md_op = MD_NONE;
      if (muldiv) begin
         for (int i = 0; i < n; i++) begin
            if (!stall_t) d_md_use = 1'($urandom_range(0, 1));
            if ((stall_t && i == 1) || (!stall_t && $urandom_range(0, 3) == 0)) begin
               md_start = 1'b1;
               md_op = stall_t ? MD_MULT : 3'($urandom_range(0, 7));
               src_a = $urandom; src_b = $urandom;
            end
            @(negedge clk);
            chk("stall_busy", stall_req, 64'(d_md_use));
            @(posedge clk); #1;
            md_start = 1'b0; md_op = MD_NONE;
         end
      end
      if (!stall_t) d_md_use = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall_req, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      issue(MD_MULT, -32'sd3, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      issue(MD_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
      issue(MD_DIV, -32'sd7, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0);
      issue(MD_DIVU, 32'd5, 32'd0, 1, 32'd0, 32'h8000_0000, 0);
      issue(MD_MTHI, 32'h1234, 32'd0, 1, 32'h1234, 32'h8000_0000, 0);
      issue(MD_MTLO, 32'h5678, 32'd0, 1, 32'h1234, 32'h5678, 0);

      // Held D-stage use: stall through the busy window, extra start ignored, released at T+6.
      issue(MD_MULT, 32'd6, 32'd9, 1, 32'd0, 32'd54, 1);
      @(negedge clk);
      chk("stall_after", stall_req, 0);
      chk("busy_after", busy, 0);
      @(posedge clk); #1;
      d_md_use = 1'b0;

      for (int k = 0; k < 40; k++)
         issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 0, '0, '0, 0);

      // Reset in the middle of a divide: nothing may ever be committed.
      issue(MD_MTHI, 32'hA5A5, 32'd0, 0, '0, '0, 0);
      issue(MD_MTLO, 32'h5A5A, 32'd0, 0, '0, '0, 0);
      md_start = 1'b1; md_op = MD_DIV; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      md_start = 1'b0; md_op = MD_NONE;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_busy", busy, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_hi = '0; m_lo = '0;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("nocommit_hi", hi, 0);
      chk("nocommit_lo", lo, 0);
      chk("nocommit_busy", busy, 0);
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++)
         issue(3'($urandom_range(1, 6)), rnd_opnd(), rnd_opnd(), 0, '0, '0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits (legal: 8..64, even).
REQ-002 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal: 1..31).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal: 1..31).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 md_start  input  1  E-stage holds a valid MD instruction this cycle.
REQ-007 md_op  input  3  MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-008 src_a  input  WIDTH  rs operand (dividend or multiplicand; mthi/mtlo data).
REQ-009 src_b  input  WIDTH  rt operand (divisor or multiplier).
REQ-010 d_md_use  input  1  D-stage instruction accesses HI/LO or the MDU (decode "start" class).
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 hi  output  WIDTH  architectural HI register.
REQ-013 lo  output  WIDTH  architectural LO register.
REQ-014 stall_req  output  1  request to freeze F/D and bubble E.

Function
REQ-015 States: IDLE, MUL, DIV; the counter is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits wide.
REQ-016 IDLE, md_start with op 1/2: compute the 2*WIDTH product (signed/unsigned) into pending {PH,PL}, load counter = MULT_CYCLES, go to MUL.
REQ-017 IDLE, md_start with op 3/4: compute quotient into pending PL and remainder into PH, load counter = DIV_CYCLES, go to DIV.
REQ-018 busy = (state != IDLE); start on edge T gives busy high in cycles T+1 .. T+N, where N is the cycle parameter.
REQ-019 Counter decrements each cycle in MUL/DIV; on the edge where it equals 1: hi<=PH, lo<=PL, state<=IDLE.
REQ-020 New hi/lo are visible in the same cycle busy falls (cycle T+N+1).
REQ-021 md_start with op 5 (mthi) writes hi<=src_a on the next edge; op 6 (mtlo) writes lo<=src_a; no busy, no state change.
REQ-022 md_start while busy is a protocol violation: ignored, with no effect on state, pending registers or hi/lo.
REQ-023 md_start with op 0 or 7: no effect.
REQ-024 Signed divide truncates toward zero; remainder takes the sign of the dividend.
REQ-025 Signed overflow (src_a = MIN, src_b = -1): quotient = MIN, remainder = 0.
REQ-026 Divide by zero (div or divu): full DIV_CYCLES busy period, then hi and lo left unchanged.
REQ-027 mult/multu: hi = upper WIDTH bits of the product, lo = lower WIDTH bits.
REQ-028 stall_req = d_md_use & (busy | (md_start & op in {1,2,3,4})), combinational.
REQ-029 stall_req falls in the cycle busy falls, so a D-stage mfhi/mflo reads committed values.

Reset
REQ-030 reset_n low asynchronously forces: state=IDLE, counter=0, hi=0, lo=0, PH=0, PL=0, busy=0, stall_req=0 (given d_md_use=0).
REQ-031 Reset mid-operation aborts the operation; the pending result is never committed.
REQ-032 After reset_n deasserts, the first accepted md_start is on the next rising edge.

Structure
REQ-033 Shared package md_pkg holds: md_op encodings (MD_NONE..MD_MTLO), state enum (IDLE/MUL/DIV), and default cycle constants.
REQ-034 The decode controller uses md_pkg encodings to drive md_op.
REQ-035 One sub-module, md_div_core (combinational WIDTH-parametrised signed/unsigned divider), owns the zero and overflow rules.
REQ-036 Multiplication stays inline.

Verification
REQ-037 mult, src_a=-3, src_b=7 (WIDTH=32, MULT_CYCLES=5) -> busy cycles T+1..T+5; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB at T+6.
REQ-038 divu, 100 / 7, then div, -7 / 2 -> first gives hi=2, lo=14; second gives hi=-1, lo=-3; each with exactly 10 busy cycles.
REQ-039 div, 32'h80000000 / -1, then divu, 5 / 0 -> first gives lo=32'h80000000, hi=0; second leaves hi/lo unchanged after 10 busy cycles.
REQ-040 mthi 32'h1234, then mtlo 32'h5678 on consecutive cycles -> hi=32'h1234, lo=32'h5678 one edge after each; busy stays 0.
REQ-041 mult issued with d_md_use=1 held -> stall_req high from the start cycle through T+5, low at T+6; an extra md_start at T+2 is ignored.
REQ-042 reset_n pulsed low at T+3 of a div -> hi=lo=0, busy=0 immediately; no commit occurs at T+11.
